// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequencer that loads a program into instruction memory,
// holds the CPU in reset for a fixed number of cycles, lets it run until it
// jumps to itself or exhausts its cycle budget, then freezes it so that its
// state can be inspected.
module mips_run_ctrl #(
  parameter int IMEM_AW    = 8,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [15:0]        ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [15:0]        imem_wdata,
  output logic               cpu_rst,
  output logic               cpu_en,
  input  logic [15:0]        pc_out,
  input  logic [15:0]        alu_out,
  output logic               done,
  output logic               halted,
  output logic               timeout,
  output logic [15:0]        cycle_count,
  output logic [15:0]        result
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CPURST,
    RUN,
    DONE
  } state_t;

  localparam logic [IMEM_AW-1:0] IDX_MAX  = '1;
  localparam logic [7:0]         RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [15:0]        CNT_LAST = 16'(MAX_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IMEM_AW-1:0] idx;
  logic [7:0]         rst_cnt;
  logic [15:0]        prev_pc;
  logic               pc_valid;
  logic               accept;
  logic               last_word;
  logic               halt_hit;
  logic               budget_hit;

  // Load handshake, memory write port and CPU control decoded from the state.
  // abort and rst suppress the handshake so no word lands in their cycle.
  always_comb begin
    ld_ready   = (state == LOAD) && !abort && !rst;
    accept     = ld_valid && ld_ready;
    imem_we    = accept;
    imem_addr  = (state == LOAD) ? idx : '0;
    imem_wdata = accept ? ld_data : 16'h0000;
    last_word  = ld_last || (idx == IDX_MAX);
    halt_hit   = pc_valid && (pc_out == prev_pc);
    budget_hit = (cycle_count == CNT_LAST);
    cpu_rst    = (state == IDLE) || (state == LOAD) || (state == CPURST);
    cpu_en     = (state == RUN);
    done       = (state == DONE);
  end

  // Next-state selection; abort overrides every other request.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that leaves state_nxt unassigned would infer a latch.
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    if (accept && last_word) state_nxt = CPURST;
        CPURST:  if (rst_cnt == RST_LAST) state_nxt = RUN;
        RUN:     if (halt_hit || budget_hit) state_nxt = DONE;
        DONE:    if (start) state_nxt = LOAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it is just the highest
    // priority branch of ordinary clocked logic rather than an async path.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word index, reset-hold counter, halt detector and status registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its peers, independent of statement order.
    if (rst) begin
      idx         <= '0;
      rst_cnt     <= '0;
      prev_pc     <= '0;
      pc_valid    <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      result      <= '0;
    end else if (abort) begin
      idx         <= '0;
      rst_cnt     <= '0;
      pc_valid    <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      result      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) idx <= '0;
        end
        LOAD: begin
          // The index parks at the last word instead of wrapping.
          if (accept && (idx != IDX_MAX)) idx <= idx + 1'b1;
          if (accept && last_word)        rst_cnt <= '0;
        end
        CPURST: begin
          rst_cnt     <= rst_cnt + 1'b1;
          pc_valid    <= 1'b0;
          cycle_count <= '0;
          halted      <= 1'b0;
          timeout     <= 1'b0;
          result      <= '0;
        end
        RUN: begin
          prev_pc  <= pc_out;
          pc_valid <= 1'b1;
          if (halt_hit) begin
            halted <= 1'b1;
            result <= alu_out;
          end else if (budget_hit) begin
            timeout <= 1'b1;
            result  <= alu_out;
          end else if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        DONE: begin
          if (start) begin
            idx         <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            result      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed bench for mips_run_ctrl with a small CPU model
// whose program counter either counts up forever or stops at a chosen value.
module tb_mips_run_ctrl;

  localparam int AW = 2;
  localparam int RC = 4;
  localparam int MC = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          ld_valid;
  logic          ld_ready;
  logic [15:0]   ld_data;
  logic          ld_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          cpu_en;
  logic [15:0]   pc_out;
  logic [15:0]   alu_out;
  logic          done;
  logic          halted;
  logic          timeout;
  logic [15:0]   cycle_count;
  logic [15:0]   result;

  logic          halt_en;
  logic [15:0]   halt_at;

  int n_vec = 0;
  int n_err = 0;

  mips_run_ctrl #(
    .IMEM_AW   (AW),
    .RST_CYCLES(RC),
    .MAX_CYCLES(MC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .pc_out     (pc_out),
    .alu_out    (alu_out),
    .done       (done),
    .halted     (halted),
    .timeout    (timeout),
    .cycle_count(cycle_count),
    .result     (result)
  );

  always #5 clk = ~clk;

  // CPU model: pc resets to 0, advances when enabled, parks at halt_at.
  always @(posedge clk) begin
    if (cpu_rst) pc_out <= 16'h0000;
    else if (cpu_en && !(halt_en && pc_out == halt_at)) pc_out <= pc_out + 16'd1;
  end

  typedef struct packed {
    logic          start;
    logic          abort;
    logic          ld_valid;
    logic          ld_last;
    logic [15:0]   ld_data;
    logic          ld_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst;
    logic          cpu_en;
    logic          done;
  } vec_t;

  vec_t tab_a [10];
  vec_t tab_b [10];

  function automatic vec_t mk(input logic st, input logic ab, input logic vl,
                              input logic la, input logic [15:0] d,
                              input logic rdy, input logic we,
                              input logic [AW-1:0] ad, input logic [15:0] wd,
                              input logic cr, input logic ce, input logic dn);
    vec_t v;
    v.start = st; v.abort = ab; v.ld_valid = vl; v.ld_last = la; v.ld_data = d;
    v.ld_ready = rdy; v.imem_we = we; v.imem_addr = ad; v.imem_wdata = wd;
    v.cpu_rst = cr; v.cpu_en = ce; v.done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] port_view();
    return 64'({ld_ready, imem_we, imem_addr, imem_wdata, cpu_rst, cpu_en, done});
  endfunction

  function automatic logic [63:0] status_view();
    return 64'({halted, timeout, cycle_count, result});
  endfunction

  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    start    = v.start;
    abort    = v.abort;
    ld_valid = v.ld_valid;
    ld_last  = v.ld_last;
    ld_data  = v.ld_data;
    #1;
    check(name, port_view(),
          64'({v.ld_ready, v.imem_we, v.imem_addr, v.imem_wdata, v.cpu_rst, v.cpu_en, v.done}));
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic load_one(input logic [15:0] d);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 16'h0000;
  endtask

  initial begin
    // Three-word program, one stall beat, four reset cycles, first run cycle.
    tab_a[0] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_a[1] = mk(0, 0, 1, 0, 16'h1234, 1, 1, 2'd0, 16'h1234, 1, 0, 0);
    tab_a[2] = mk(0, 0, 0, 0, 16'hFFFF, 1, 0, 2'd1, 16'h0000, 1, 0, 0);
    tab_a[3] = mk(0, 0, 1, 0, 16'h5678, 1, 1, 2'd1, 16'h5678, 1, 0, 0);
    tab_a[4] = mk(0, 0, 1, 1, 16'h9ABC, 1, 1, 2'd2, 16'h9ABC, 1, 0, 0);
    tab_a[5] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_a[6] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_a[7] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_a[8] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_a[9] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1, 0);
    // Overflow: start from DONE, five beats into a four-word memory.
    tab_b[0] = mk(1, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 0, 1);
    tab_b[1] = mk(0, 0, 1, 0, 16'h00A0, 1, 1, 2'd0, 16'h00A0, 1, 0, 0);
    tab_b[2] = mk(0, 0, 1, 0, 16'h00A1, 1, 1, 2'd1, 16'h00A1, 1, 0, 0);
    tab_b[3] = mk(0, 0, 1, 0, 16'h00A2, 1, 1, 2'd2, 16'h00A2, 1, 0, 0);
    tab_b[4] = mk(0, 0, 1, 0, 16'h00A3, 1, 1, 2'd3, 16'h00A3, 1, 0, 0);
    tab_b[5] = mk(0, 0, 1, 0, 16'h00A4, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_b[6] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_b[7] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_b[8] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 0);
    tab_b[9] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1, 0);

    rst = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 16'h0000; alu_out = 16'h00AA; halt_en = 1'b1; halt_at = 16'h0004;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_ports", port_view(), 64'({1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0}));
    check("reset_status", status_view(), 64'd0);
    rst = 1'b0;

    // Load and halt at pc 4: halt seen in run cycle 6 with cycle_count 5.
    for (int i = 0; i < 10; i++) apply_vec(tab_a[i], $sformatf("load_halt[%0d]", i));
    wait_done(30, "halt_done");
    check("halt_flags", 64'({halted, timeout}), 64'b10);
    check("halt_result", 64'(result), 64'h00AA);
    check("halt_count", 64'(cycle_count), 64'd5);
    check("halt_cpu_ctl", 64'({cpu_rst, cpu_en, done}), 64'b001);

    // DONE holds everything even as the CPU side changes.
    alu_out = 16'h1111;
    repeat (2) @(negedge clk);
    #1;
    check("done_hold_status", status_view(), 64'({1'b1, 1'b0, 16'd5, 16'h00AA}));
    check("done_hold_done", 64'(done), 64'd1);

    // Rerun into a timeout, with start pulses in CPURST and RUN ignored.
    halt_en = 1'b0; alu_out = 16'h0055;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("rerun_cleared", 64'({done, halted, timeout, cycle_count, result}), 64'd0);
    check("rerun_ready", 64'(ld_ready), 64'd1);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 16'h0042;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    #1;
    check("run_en", 64'({cpu_rst, cpu_en}), 64'b01);
    @(negedge clk);
    start = 1'b0;
    wait_done(40, "timeout_done");
    check("timeout_flags", 64'({halted, timeout}), 64'b01);
    check("timeout_count", 64'(cycle_count), 64'd9);
    check("timeout_result", 64'(result), 64'h0055);

    // Halt in the same cycle the budget runs out: halt wins.
    halt_en = 1'b1; halt_at = 16'h0008; alu_out = 16'h0077;
    load_one(16'h0099);
    wait_done(40, "coincide_done");
    check("coincide_flags", 64'({halted, timeout}), 64'b10);
    check("coincide_count", 64'(cycle_count), 64'd9);
    check("coincide_result", 64'(result), 64'h0077);

    // Overflowing load, then abort in run cycle 3.
    halt_en = 1'b0;
    for (int i = 0; i < 10; i++) apply_vec(tab_b[i], $sformatf("overflow[%0d]", i));
    ld_valid = 1'b0;
    @(negedge clk);
    #1;
    check("abort_run2_count", 64'(cycle_count), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_cycle_en", 64'(cpu_en), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_ports", port_view(), 64'({1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0}));
    check("abort_status", status_view(), 64'd0);

    // Reset together with abort in the middle of a load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b1; ld_data = 16'hBEEF;
    #1;
    check("mid_load_write", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 2'd0, 16'hBEEF}));
    @(negedge clk);
    ld_data = 16'hCAFE; rst = 1'b1; abort = 1'b1;
    #1;
    check("rst_abort_we", 64'(imem_we), 64'd0);
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    #1;
    check("rst_abort_ports", port_view(), 64'({1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0}));
    check("rst_abort_status", status_view(), 64'd0);
    @(negedge clk);
    #1;
    check("rst_abort_no_write", 64'({imem_we, ld_ready}), 64'd0);
    ld_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, meaning instruction-memory address width (depth 2^IMEM_AW words).
REQ-002 SHALL have parameter RST_CYCLES, default 4, meaning the number of cycles cpu_rst is held after load; the legal range is 1..255.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000, meaning the run-cycle budget before timeout; the legal range is 1..65535.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a single-cycle request to load and run a program.
REQ-007 SHALL have port abort, input, 1, which cancels any operation in progress.
REQ-008 SHALL have ports ld_valid (input, 1), ld_ready (output, 1), ld_data (input, 16) and ld_last (input, 1), forming the program-load stream.
REQ-009 SHALL have ports imem_we (output, 1), imem_addr (output, IMEM_AW) and imem_wdata (output, 16), forming the instruction-memory write port.
REQ-010 SHALL have ports cpu_rst (output, 1) and cpu_en (output, 1), which are the CPU reset and clock-enable.
REQ-011 SHALL have ports pc_out (input, 16) and alu_out (input, 16), which are observed from the CPU.
REQ-012 SHALL have outputs done (1), halted (1), timeout (1), cycle_count (16) and result (16).

Function
REQ-013 SHALL implement states IDLE, LOAD, CPURST, RUN and DONE, encoded as a single registered state variable.
REQ-014 IDLE SHALL drive cpu_rst=1, cpu_en=0 and ld_ready=0; start=1 SHALL go to LOAD and set imem_addr=0.
REQ-015 LOAD SHALL drive ld_ready=1 and cpu_rst=1.
REQ-016 In LOAD, each ld_valid&&ld_ready cycle SHALL drive imem_we=1, imem_wdata=ld_data and imem_addr=the word index, combinationally in the same cycle.
REQ-017 In LOAD, the word index SHALL increment after each write.
REQ-018 In LOAD, a write with ld_last=1, or a write at index 2^IMEM_AW-1, SHALL go to CPURST; the index SHALL NOT wrap.
REQ-019 In LOAD, ld_valid=0 SHALL hold the state; imem_we SHALL be 0 in every cycle with no accepted beat.
REQ-020 CPURST SHALL drive cpu_rst=1 and cpu_en=0 for exactly RST_CYCLES cycles, then go to RUN.
REQ-021 CPURST SHALL clear cycle_count, halted, timeout and result.
REQ-022 RUN SHALL drive cpu_rst=0 and cpu_en=1.
REQ-023 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at 16'hFFFF.
REQ-024 In RUN, pc_out SHALL be registered into prev_pc with a valid flag; the valid flag is cleared on entry to RUN.
REQ-025 Halt SHALL be detected in RUN when prev_pc is valid and pc_out==prev_pc, i.e. a jump-to-self.
REQ-026 On halt, the block SHALL go to DONE with halted=1 and result=alu_out sampled in that cycle.
REQ-027 In RUN, when cycle_count==MAX_CYCLES-1 and no halt is detected, the block SHALL go to DONE with timeout=1 and result=alu_out.
REQ-028 When halt and timeout coincide, halt SHALL win: halted=1 and timeout=0.
REQ-029 DONE SHALL drive done=1, cpu_en=0 and cpu_rst=0 so that CPU state is frozen and inspectable.
REQ-030 In DONE, done, halted, timeout, cycle_count and result SHALL hold stable.
REQ-031 In DONE, start=1 SHALL go to LOAD and clear done, halted, timeout, cycle_count and result.
REQ-032 start SHALL be ignored in LOAD, CPURST and RUN.
REQ-033 abort=1 in any state other than IDLE SHALL go to IDLE next cycle.
REQ-034 abort SHALL take priority over start, ld_last, halt and timeout in the same cycle.
REQ-035 On abort, imem_we SHALL be 0 in the abort cycle, and all status outputs SHALL be cleared.
REQ-036 halted and timeout SHALL never both be 1.
REQ-037 done SHALL be 1 only in DONE.

Reset
REQ-038 rst=1 SHALL take priority over all other inputs, including abort.
REQ-039 rst SHALL force state=IDLE, cpu_rst=1 and cpu_en=0 on the next edge.
REQ-040 rst SHALL force ld_ready=0, imem_we=0, imem_addr=0 and imem_wdata=0 on the next edge.
REQ-041 rst SHALL force done=0, halted=0, timeout=0, cycle_count=0, result=0, the word index to 0 and the prev_pc valid flag to 0 on the next edge.
REQ-042 rst asserted mid-LOAD or mid-RUN SHALL abandon the operation with no further imem writes.

Verification
REQ-043 Load and halt: start; stream 3 words 0x1234, 0x5678, 0x9ABC with ld_last on the third -> imem writes at addr 0, 1, 2; cpu_rst high for 4 cycles; CPU model holds pc_out=0x0004 from run cycle 5 with alu_out=0x00AA -> done=1, halted=1, timeout=0, result=0x00AA.
REQ-044 Timeout: MAX_CYCLES=10 with a CPU model whose pc increments every cycle -> DONE after 10 RUN cycles, cycle_count=9, timeout=1, halted=0.
REQ-045 Coincident halt and timeout: halt condition in the cycle where cycle_count==MAX_CYCLES-1 -> halted=1, timeout=0.
REQ-046 Load backpressure and overflow: IMEM_AW=2 with 5 valid beats and no ld_last -> exactly 4 writes (addr 0..3), then CPURST; the 5th beat is not accepted (ld_ready=0).
REQ-047 Abort and reset mid-run: abort in RUN cycle 3 -> IDLE, cpu_rst=1, done=0. Separately, rst together with abort mid-LOAD -> IDLE with all outputs at reset values and no imem_we after that edge.
REQ-048 Rerun: start in DONE -> status cleared on entry to LOAD; a second program completes with a fresh cycle_count.
